ysyx_23060042_exec_ctrl: RTL and testbench

//   Multi-cycle instruction sequencer for the NPC core. Owns the PC register, runs the

---
 rtl/ysyx_23060042_exec_ctrl.sv | 156 +++++++++++++++
 tb/tb_ysyx_23060042_exec_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060042_exec_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the NPC core: PC owner, bus handshakes, timeout/halt.
// Optional perf counters: define YSYX_23060042_EXEC_CTRL_PERF_EN to add perf_cycles/perf_instret.
module ysyx_23060042_exec_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 256,
  parameter int unsigned CNT_W    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [31:0]       pc,
  output logic              if_req_valid,
  input  logic              if_req_ready,
  input  logic              if_rsp_valid,
  input  logic [31:0]       if_rdata,
  output logic [31:0]       inst,
  input  logic              dec_pcren,
  input  logic              dec_is_load,
  input  logic              dec_is_store,
  input  logic              dec_is_ebreak,
  input  logic              dec_rd_we,
  input  logic [31:0]       next_pc,
  output logic              exu_pcren,
  input  logic [31:0]       exu_wdata,
  output logic [31:0]       alu_q,
  output logic              lsu_req_valid,
  input  logic              lsu_req_ready,
  input  logic              lsu_rsp_valid,
  output logic              reg_we,
  output logic              halt,
`ifdef YSYX_23060042_EXEC_CTRL_PERF_EN
  output logic [CNT_W-1:0]  perf_cycles,
  output logic [CNT_W-1:0]  perf_instret,
`endif
  output logic              fault
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t            state, state_nxt;
  logic              if_acc, if_acc_nxt;
  logic              lsu_acc, lsu_acc_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              fault_nxt;
  logic              waiting;
  logic              fetch_hs, fetch_done;
  logic              mem_hs, mem_done;

  // A response is only meaningful once its request has been (or is being) accepted.
  assign fetch_hs   = (state == S_FETCH) & ~if_acc & if_req_ready;
  assign fetch_done = (state == S_FETCH) & (if_acc | if_req_ready) & if_rsp_valid;
  assign mem_hs     = (state == S_MEM) & ~lsu_acc & lsu_req_ready;
  assign mem_done   = (state == S_MEM) & (lsu_acc | lsu_req_ready) & lsu_rsp_valid;

  // Fetch request is masked while reset is held so no request leaks out during reset.
  assign if_req_valid  = rst_n & (state == S_FETCH) & ~if_acc;
  assign lsu_req_valid = (state == S_MEM) & ~lsu_acc;
  assign reg_we        = (state == S_WB) & dec_rd_we & ~dec_is_store;
  assign halt          = (state == S_HALT);

  always_comb begin
    state_nxt   = state;
    if_acc_nxt  = if_acc;
    lsu_acc_nxt = lsu_acc;
    wcnt_nxt    = wcnt;
    fault_nxt   = fault;
    waiting     = 1'b0;
    case (state)
      S_FETCH: begin
        if (fetch_done) begin
          state_nxt  = S_DECODE;
          if_acc_nxt = 1'b0;
        end else if (fetch_hs) begin
          if_acc_nxt = 1'b1;
          wcnt_nxt   = '0;
        end else begin
          waiting = 1'b1;
        end
      end
      S_DECODE: state_nxt = dec_is_ebreak ? S_HALT : S_EXEC;
      S_EXEC:   state_nxt = (dec_is_load | dec_is_store) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_done) begin
          state_nxt   = S_WB;
          lsu_acc_nxt = 1'b0;
        end else if (mem_hs) begin
          lsu_acc_nxt = 1'b1;
          wcnt_nxt    = '0;
        end else begin
          waiting = 1'b1;
        end
      end
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
    if (waiting) begin
      if (wcnt == WCNT_LAST) begin
        state_nxt   = S_HALT;
        fault_nxt   = 1'b1;
        if_acc_nxt  = 1'b0;
        lsu_acc_nxt = 1'b0;
      end else begin
        wcnt_nxt = wcnt + WCNT_W'(1);
      end
    end
    if (state_nxt != state) wcnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      if_acc  <= 1'b0;
      lsu_acc <= 1'b0;
      wcnt    <= '0;
      fault   <= 1'b0;
    end else begin
      state   <= state_nxt;
      if_acc  <= if_acc_nxt;
      lsu_acc <= lsu_acc_nxt;
      wcnt    <= wcnt_nxt;
      fault   <= fault_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      inst      <= '0;
      alu_q     <= '0;
      exu_pcren <= 1'b0;
    end else begin
      if (fetch_done)         inst      <= if_rdata;
      if (state == S_DECODE)  exu_pcren <= dec_pcren;
      if (state == S_EXEC)    alu_q     <= exu_wdata;
      if (state == S_WB)      pc        <= next_pc;
    end
  end

`ifdef YSYX_23060042_EXEC_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles  <= '0;
      perf_instret <= '0;
    end else if (!halt) begin
      perf_cycles <= perf_cycles + CNT_W'(1);
      if (state == S_WB) perf_instret <= perf_instret + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060042_exec_ctrl.sv
// Randomized bench for ysyx_23060042_exec_ctrl: transaction-level expectation model plus directed literal checks.
module tb_ysyx_23060042_exec_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_rdata, inst;
  logic        dec_pcren, dec_is_load, dec_is_store, dec_is_ebreak, dec_rd_we;
  logic [31:0] next_pc, exu_wdata, alu_q;
  logic        exu_pcren;
  logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
  logic        reg_we, halt, fault;
`ifdef YSYX_23060042_EXEC_CTRL_PERF_EN
  logic [63:0] perf_cycles, perf_instret;
`endif

  ysyx_23060042_exec_ctrl #(.RESET_PC(RST_PC), .TIMEOUT(TO), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata), .inst(inst),
    .dec_pcren(dec_pcren), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_is_ebreak(dec_is_ebreak), .dec_rd_we(dec_rd_we), .next_pc(next_pc),
    .exu_pcren(exu_pcren), .exu_wdata(exu_wdata), .alu_q(alu_q),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .reg_we(reg_we), .halt(halt),
`ifdef YSYX_23060042_EXEC_CTRL_PERF_EN
    .perf_cycles(perf_cycles), .perf_instret(perf_instret),
`endif
    .fault(fault)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Expected architectural view, advanced one transaction phase at a time.
  logic [31:0] exp_pc, exp_inst, exp_alu;
  logic        exp_pcren, exp_if, exp_lsu, exp_we, exp_halt, exp_fault;
  logic [63:0] exp_cycles, exp_instret;
  bit          chk_en = 1'b0;
  int          cycle_no, we_cycle, lsu_hi, we_cnt, if_hi;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", {32'd0, pc}, {32'd0, exp_pc});
      chk("if_req_valid", {63'd0, if_req_valid}, {63'd0, exp_if});
      chk("lsu_req_valid", {63'd0, lsu_req_valid}, {63'd0, exp_lsu});
      chk("reg_we", {63'd0, reg_we}, {63'd0, exp_we});
      chk("halt", {63'd0, halt}, {63'd0, exp_halt});
      chk("fault", {63'd0, fault}, {63'd0, exp_fault});
      chk("inst", {32'd0, inst}, {32'd0, exp_inst});
      chk("alu_q", {32'd0, alu_q}, {32'd0, exp_alu});
      chk("exu_pcren", {63'd0, exu_pcren}, {63'd0, exp_pcren});
`ifdef YSYX_23060042_EXEC_CTRL_PERF_EN
      chk("perf_cycles", perf_cycles, exp_cycles);
      chk("perf_instret", perf_instret, exp_instret);
`endif
      if (reg_we) begin
        we_cnt++;
        if (we_cycle == 0) we_cycle = cycle_no;
      end
      if (lsu_req_valid) lsu_hi++;
      if (if_req_valid) if_hi++;
    end
  end

  task automatic tick();
    logic h;
    h = exp_halt;
    @(posedge clk); #1;
    cycle_no++;
    if (!h) exp_cycles++;
  endtask

  task automatic drive_idle(input bit keep_dec);
    if_req_ready  = 1'($urandom_range(0, 1));
    if_rsp_valid  = 1'($urandom_range(0, 1));
    if_rdata      = $urandom;
    lsu_req_ready = 1'($urandom_range(0, 1));
    lsu_rsp_valid = 1'($urandom_range(0, 1));
    exu_wdata     = $urandom;
    next_pc       = $urandom;
    if (!keep_dec) begin
      dec_pcren     = 1'($urandom_range(0, 1));
      dec_is_load   = 1'($urandom_range(0, 1));
      dec_is_store  = 1'($urandom_range(0, 1));
      dec_is_ebreak = 1'($urandom_range(0, 1));
      dec_rd_we     = 1'($urandom_range(0, 1));
    end
    exp_if  = 1'b0;
    exp_lsu = 1'b0;
    exp_we  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_pc = RST_PC; exp_inst = '0; exp_alu = '0; exp_pcren = 1'b0;
    exp_if = 1'b0; exp_lsu = 1'b0; exp_we = 1'b0; exp_halt = 1'b0; exp_fault = 1'b0;
    exp_cycles = '0; exp_instret = '0;
    #1;
    chk("rst_pc", {32'd0, pc}, 64'h8000_0000);
    chk("rst_lsu_valid", {63'd0, lsu_req_valid}, 64'd0);
    chk("rst_if_valid", {63'd0, if_req_valid}, 64'd0);
    chk("rst_fault", {63'd0, fault}, 64'd0);
    repeat (2) begin
      drive_idle(1'b0);
      lsu_rsp_valid = 1'b1;
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    cycle_no = 1;
    we_cycle = 0;
  endtask

  task automatic fetch_phase(input int fr, input int rw, input logic [31:0] word);
    for (int i = 0; i <= fr; i++) begin
      drive_idle(1'b0);
      if_req_ready = (i == fr);
      if_rsp_valid = (i == fr) && (rw == 0);
      if (if_rsp_valid) if_rdata = word;
      exp_if = 1'b1;
      tick();
    end
    for (int j = 1; j <= rw; j++) begin
      drive_idle(1'b0);
      if_rsp_valid = (j == rw);
      if (if_rsp_valid) if_rdata = word;
      tick();
    end
    exp_inst = word;
  endtask

  task automatic decode_exec(input int kind, input logic rd_we, input logic pcren, input logic [31:0] w);
    dec_is_load = (kind == 1); dec_is_store = (kind == 2); dec_is_ebreak = (kind == 3);
    dec_rd_we = rd_we; dec_pcren = pcren;
    drive_idle(1'b1);
    tick();
    exp_pcren = pcren;
    if (kind == 3) begin
      exp_halt = 1'b1;
      return;
    end
    drive_idle(1'b1);
    exu_wdata = w;
    tick();
    exp_alu = w;
  endtask

  task automatic mem_phase(input int lr, input int lw);
    for (int i = 0; i <= lr; i++) begin
      drive_idle(1'b1);
      lsu_req_ready = (i == lr);
      lsu_rsp_valid = 1'b0;
      exp_lsu = 1'b1;
      tick();
    end
    for (int j = 1; j <= lw; j++) begin
      drive_idle(1'b1);
      lsu_rsp_valid = (j == lw);
      tick();
    end
  endtask

  task automatic run_instr(input int kind, input logic rd_we, input logic pcren, input int fr, input int rw,
                           input int lr, input int lw, input logic [31:0] np, input logic [31:0] w);
    fetch_phase(fr, rw, $urandom);
    decode_exec(kind, rd_we, pcren, w);
    if (kind == 3) return;
    if (kind == 1 || kind == 2) mem_phase(lr, lw);
    drive_idle(1'b1);
    next_pc = np;
    exp_we = rd_we && (kind != 2);
    tick();
    exp_pc = np;
    exp_instret++;
  endtask

  task automatic run_random(input int n);
    for (int t = 0; t < n; t++) begin
      logic [31:0] np;
      np = ($urandom_range(0, 3) == 0) ? $urandom : exp_pc + 32'd4;
      run_instr($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(1, 3), np, $urandom);
    end
  endtask

  initial begin
    int first;
    rst_n = 1'b0;
    drive_idle(1'b0);
    @(posedge clk); #1;
    chk_en = 1'b1;
    do_reset();

    // addi x1,x0,5 with zero-wait fetch
    run_instr(0, 1'b1, 1'b0, 0, 0, 0, 1, 32'h8000_0004, 32'd5);
    chk("addi_we_cycle", 64'(we_cycle), 64'd4);
    chk("addi_pc", {32'd0, pc}, 64'h8000_0004);
    chk("addi_alu", {32'd0, alu_q}, 64'd5);

    // auipc-class: src1 = pc
    run_instr(0, 1'b1, 1'b1, 0, 0, 0, 1, 32'h8000_0008, 32'h8000_1004);
    chk("auipc_alu", {32'd0, alu_q}, 64'h8000_1004);
    chk("auipc_pcren", {63'd0, exu_pcren}, 64'd1);

    // lw with slow LSU
    lsu_hi = 0; we_cnt = 0;
    run_instr(1, 1'b1, 1'b0, 0, 0, 3, 2, 32'h8000_000c, 32'h8000_0100);
    chk("lw_valid_cycles", 64'(lsu_hi), 64'd4);
    chk("lw_we_count", 64'(we_cnt), 64'd1);

    // store never writes rd; pc wraps through 0
    we_cnt = 0;
    run_instr(2, 1'b1, 1'b0, 1, 2, 0, 1, 32'hFFFF_FFFC, $urandom);
    run_instr(0, 1'b0, 1'b0, 0, 1, 0, 1, 32'h0000_0000, $urandom);
    chk("store_we_count", 64'(we_cnt), 64'd0);
    chk("wrap_pc", {32'd0, pc}, 64'd0);

    run_random(40);

    // ebreak after three instructions
    do_reset();
    run_random(3);
    run_instr(3, 1'b0, 1'b0, 0, 0, 0, 1, 32'h0, 32'h0);
    if_hi = 0;
    repeat (6) begin drive_idle(1'b0); tick(); end
    chk("ebreak_halt", {63'd0, halt}, 64'd1);
    chk("ebreak_fault", {63'd0, fault}, 64'd0);
    chk("ebreak_no_fetch", 64'(if_hi), 64'd0);
`ifdef YSYX_23060042_EXEC_CTRL_PERF_EN
    chk("ebreak_instret", perf_instret, 64'd3);
`endif

    // reset while waiting for an LSU response
    do_reset();
    run_instr(0, 1'b1, 1'b0, 0, 0, 0, 1, 32'h1234_5678, $urandom);
    fetch_phase(0, 0, $urandom);
    decode_exec(1, 1'b1, 1'b0, $urandom);
    drive_idle(1'b1); lsu_req_ready = 1'b1; lsu_rsp_valid = 1'b0; exp_lsu = 1'b1; tick();
    repeat (2) begin drive_idle(1'b1); lsu_rsp_valid = 1'b0; tick(); end
    drive_idle(1'b1); lsu_rsp_valid = 1'b0;
    do_reset();
    drive_idle(1'b0); if_req_ready = 1'b0; if_rsp_valid = 1'b1; lsu_rsp_valid = 1'b1; exp_if = 1'b1;
    #1;
    chk("post_rst_if_valid", {63'd0, if_req_valid}, 64'd1);
    chk("post_rst_lsu_valid", {63'd0, lsu_req_valid}, 64'd0);
    tick();
    run_random(4);

    // fetch response never arrives
    do_reset();
    drive_idle(1'b0); if_req_ready = 1'b1; if_rsp_valid = 1'b0; exp_if = 1'b1; tick();
    first = 0;
    for (int k = 1; k <= TO + 2; k++) begin
      drive_idle(1'b0); if_rsp_valid = 1'b0;
      tick();
      if (k == TO) begin exp_fault = 1'b1; exp_halt = 1'b1; end
      if (fault && first == 0) first = k;
    end
    chk("to_fetch_cycles", 64'(first), 64'd8);

    // LSU never accepts
    do_reset();
    fetch_phase(0, 0, $urandom);
    decode_exec(2, 1'b0, 1'b0, $urandom);
    first = 0;
    for (int k = 1; k <= TO + 2; k++) begin
      drive_idle(1'b1); lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
      exp_lsu = !exp_halt;
      tick();
      if (k == TO) begin exp_fault = 1'b1; exp_halt = 1'b1; end
      if (fault && first == 0) first = k;
    end
    chk("to_lsu_cycles", 64'(first), 64'd8);
    chk("to_lsu_halt", {63'd0, halt}, 64'd1);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
